// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared types and AXI constants for the single-outstanding read master.
package ysyx_22041207_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_RESP = 2'd3
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   // Unsupported byte counts fall back to a full 8-byte beat.
   function automatic logic [2:0] size_to_arsize(input logic [7:0] size);
      case (size)
         8'd1:    return 3'd0;
         8'd2:    return 3'd1;
         8'd4:    return 3'd2;
         default: return 3'd3;
      endcase
   endfunction

   function automatic logic size_is_legal(input logic [7:0] size);
      return (size == 8'd1) || (size == 8'd2) || (size == 8'd4) || (size == 8'd8);
   endfunction

   // EXOKAY is an error here: this master never issues exclusive accesses.
   function automatic logic resp_is_err(input logic [1:0] resp);
      case (resp)
         RESP_OKAY:                              return 1'b0;
         RESP_EXOKAY, RESP_SLVERR, RESP_DECERR:  return 1'b1;
         default:                                return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22041207_rd_align.sv
// Extracts the addressed bytes from a 64-bit R beat, zero-extended.
module ysyx_22041207_rd_align
   import ysyx_22041207_axi_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  offset_i,
   input  logic [7:0]  size_i,
   output logic [63:0] data_o
);

   logic [63:0] shifted;

   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      case (size_to_arsize(size_i))
         3'd0:    data_o = {56'd0, shifted[7:0]};
         3'd1:    data_o = {48'd0, shifted[15:0]};
         3'd2:    data_o = {32'd0, shifted[31:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_22041207_axi_rd_master.sv
// Single-beat AXI4 read master behind the IF/MEM arbiter; one read in flight.
//
//   state   | meaning
//   IDLE    | ready for a request from the arbiter
//   AR      | address phase, AR fields held until arready
//   R       | waiting for the single R beat
//   RESP    | load data/err presented until the arbiter takes it
module ysyx_22041207_axi_rd_master
   import ysyx_22041207_axi_pkg::*;
#(
   parameter int RW_DATA_WIDTH  = 64,
   parameter int RW_ADDR_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 1,
   parameter int AR_ID          = 0
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      rw_valid_i,
   output logic                      rw_ready_o,
   input  logic [RW_ADDR_WIDTH-1:0]  rw_addr_i,
   input  logic [7:0]                rw_size_i,
   output logic [RW_DATA_WIDTH-1:0]  data_read_o,
   output logic                      data_valid_o,
   input  logic                      data_ready_i,
   output logic                      err_o,

   output logic                      axi_ar_valid_o,
   input  logic                      axi_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
   output logic [7:0]                axi_ar_len_o,
   output logic [2:0]                axi_ar_size_o,
   output logic [1:0]                axi_ar_burst_o,
   output logic [AXI_USER_WIDTH-1:0] axi_ar_user_o,

   input  logic                      axi_r_valid_i,
   output logic                      axi_r_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
   input  logic [1:0]                axi_r_resp_i,
   input  logic                      axi_r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i
);

   rd_state_e                state_q, state_d;
   logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]               size_q, size_d;
   logic [63:0]              data_q, data_d;
   logic                     err_q, err_d;
   logic [63:0]              aligned;

   // RID is deliberately not checked with only one read outstanding.
   logic unused_r_id;
   assign unused_r_id = ^axi_r_id_i;

   ysyx_22041207_rd_align u_align (
      .rdata_i  (axi_r_data_i),
      .offset_i (addr_q[2:0]),
      .size_i   (size_q),
      .data_o   (aligned)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (rw_valid_i) begin
               addr_d  = rw_addr_i;
               size_d  = rw_size_i;
               state_d = ST_AR;
            end
         end
         ST_AR: begin
            if (axi_ar_ready_i) state_d = ST_R;
         end
         ST_R: begin
            if (axi_r_valid_i) begin
               data_d  = aligned;
               err_d   = resp_is_err(axi_r_resp_i) | ~axi_r_last_i | ~size_is_legal(size_q);
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (data_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign rw_ready_o     = (state_q == ST_IDLE);
   assign axi_ar_valid_o = (state_q == ST_AR);
   assign axi_r_ready_o  = (state_q == ST_R);
   assign data_valid_o   = (state_q == ST_RESP);
   assign data_read_o    = RW_DATA_WIDTH'(data_q);
   assign err_o          = err_q;

   assign axi_ar_addr_o  = AXI_ADDR_WIDTH'(addr_q);
   assign axi_ar_id_o    = AXI_ID_WIDTH'(AR_ID);
   assign axi_ar_len_o   = 8'd0;
   assign axi_ar_size_o  = size_to_arsize(size_q);
   assign axi_ar_burst_o = BURST_INCR;
   assign axi_ar_user_o  = '0;

endmodule

// File: tb/tb_ysyx_22041207_axi_rd_master.sv
// Bench for the AXI read master: directed cases plus randomized traffic vs a transaction model.
module tb_ysyx_22041207_axi_rd_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rw_valid_i = 1'b0;
   logic        rw_ready_o;
   logic [63:0] rw_addr_i = '0;
   logic [7:0]  rw_size_i = '0;
   logic [63:0] data_read_o;
   logic        data_valid_o;
   logic        data_ready_i = 1'b0;
   logic        err_o;
   logic        axi_ar_valid_o;
   logic        axi_ar_ready_i = 1'b0;
   logic [63:0] axi_ar_addr_o;
   logic [3:0]  axi_ar_id_o;
   logic [7:0]  axi_ar_len_o;
   logic [2:0]  axi_ar_size_o;
   logic [1:0]  axi_ar_burst_o;
   logic [0:0]  axi_ar_user_o;
   logic        axi_r_valid_i = 1'b0;
   logic        axi_r_ready_o;
   logic [63:0] axi_r_data_i = '0;
   logic [1:0]  axi_r_resp_i = '0;
   logic        axi_r_last_i = 1'b0;
   logic [3:0]  axi_r_id_i = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ysyx_22041207_axi_rd_master dut (
      .clk(clk), .rst(rst),
      .rw_valid_i(rw_valid_i), .rw_ready_o(rw_ready_o), .rw_addr_i(rw_addr_i),
      .rw_size_i(rw_size_i), .data_read_o(data_read_o), .data_valid_o(data_valid_o),
      .data_ready_i(data_ready_i), .err_o(err_o),
      .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
      .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o),
      .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_user_o(axi_ar_user_o),
      .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o), .axi_r_data_i(axi_r_data_i),
      .axi_r_resp_i(axi_r_resp_i), .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference rules: byte count -> log2, unsupported counts read the whole beat.
   function automatic logic [2:0] m_arsize(input logic [7:0] size);
      for (int k = 0; k < 4; k++)
         if (size == 8'(1 << k)) return 3'(k);
      return 3'd3;
   endfunction

   function automatic bit m_legal(input logic [7:0] size);
      return size == 8'd1 || size == 8'd2 || size == 8'd4 || size == 8'd8;
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] rd, input int off, input int nbytes);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < nbytes; b++)
         if (off + b < 8) r[b*8 +: 8] = rd[(off+b)*8 +: 8];
      return r;
   endfunction

   // ---------------- slave model (acts 2ns after each rising edge) ----------------
   int          s_ar_delay = 0;
   int          s_r_delay  = 0;
   logic [63:0] s_rdata    = '0;
   logic [1:0]  s_rresp    = '0;
   logic        s_rlast    = 1'b1;

   int ar_cnt = 0;
   int r_cnt  = -1;
   bit last_arv = 0, last_rr = 0, last_rst = 1;

   always @(posedge clk) begin
      #2;
      if (last_rst) begin
         axi_ar_ready_i = 1'b0;
         axi_r_valid_i  = 1'b0;
         ar_cnt = 0;
         r_cnt  = -1;
      end else begin
         if (axi_ar_ready_i && last_arv) begin
            axi_ar_ready_i = 1'b0;
            ar_cnt = 0;
            r_cnt  = s_r_delay;
         end
         if (axi_r_valid_i && last_rr) axi_r_valid_i = 1'b0;
      end
      if (axi_ar_valid_o === 1'b1 && !axi_ar_ready_i) begin
         if (ar_cnt >= s_ar_delay) axi_ar_ready_i = 1'b1;
         else ar_cnt++;
      end
      if (r_cnt >= 0 && !axi_r_valid_i) begin
         if (r_cnt == 0) begin
            axi_r_valid_i = 1'b1;
            axi_r_data_i  = s_rdata;
            axi_r_resp_i  = s_rresp;
            axi_r_last_i  = s_rlast;
            axi_r_id_i    = 4'($urandom);
            r_cnt = -1;
         end else begin
            r_cnt--;
         end
      end
      last_arv = (axi_ar_valid_o === 1'b1);
      last_rr  = (axi_r_ready_o === 1'b1);
      last_rst = rst;
   end

   // ---------------- transaction model + per-cycle compare (falling edge) ----------------
   bit          known = 0;
   bit          busy = 0, ar_done = 0, r_done = 0;
   logic [63:0] m_addr = '0;
   logic [7:0]  m_size = '0;
   logic [63:0] m_data = '0;
   logic        m_err  = 1'b0;
   bit          p_arv = 0, p_ardy = 0, p_rst = 1;
   logic [63:0] p_addr = '0;

   always @(negedge clk) begin
      if (known) begin
         chk1("rw_ready",   rw_ready_o,     1'(!busy));
         chk1("ar_valid",   axi_ar_valid_o, 1'(busy && !ar_done));
         chk1("r_ready",    axi_r_ready_o,  1'(ar_done && !r_done));
         chk1("data_valid", data_valid_o,   1'(r_done));
         if (busy && !ar_done) begin
            chk("ar_addr",  axi_ar_addr_o, m_addr);
            chk("ar_size",  64'(axi_ar_size_o), 64'(m_arsize(m_size)));
            chk("ar_len",   64'(axi_ar_len_o), 64'd0);
            chk("ar_burst", 64'(axi_ar_burst_o), 64'd1);
            chk("ar_id",    64'(axi_ar_id_o), 64'd0);
            chk("ar_user",  64'(axi_ar_user_o), 64'd0);
         end
         if (r_done) begin
            chk("load_data", data_read_o, m_data);
            chk1("load_err", err_o, m_err);
         end
         if (p_arv && !p_ardy && !p_rst) begin
            chk1("ar_valid_held", axi_ar_valid_o, 1'b1);
            chk("ar_addr_stable", axi_ar_addr_o, p_addr);
         end
      end
      p_arv  = (axi_ar_valid_o === 1'b1);
      p_ardy = axi_ar_ready_i;
      p_rst  = rst;
      p_addr = axi_ar_addr_o;

      if (rst) begin
         busy = 0; ar_done = 0; r_done = 0; known = 1;
      end else if (known) begin
         if (!busy) begin
            if (rw_valid_i) begin
               busy = 1; m_addr = rw_addr_i; m_size = rw_size_i;
            end
         end else if (!ar_done) begin
            if (axi_ar_ready_i) ar_done = 1;
         end else if (!r_done) begin
            if (axi_r_valid_i) begin
               r_done = 1;
               m_data = m_load(axi_r_data_i, int'(m_addr[2:0]), m_legal(m_size) ? int'(m_size) : 8);
               m_err  = (axi_r_resp_i != 2'b00) || !axi_r_last_i || !m_legal(m_size);
            end
         end else if (data_ready_i) begin
            busy = 0; ar_done = 0; r_done = 0;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slave(input int ard, input int rd, input logic [63:0] data,
                            input logic [1:0] resp, input logic last);
      s_ar_delay = ard; s_r_delay = rd; s_rdata = data; s_rresp = resp; s_rlast = last;
   endtask

   task automatic issue(input logic [63:0] a, input logic [7:0] s, output int acc);
      int n;
      rw_valid_i = 1'b1; rw_addr_i = a; rw_size_i = s;
      n = 0;
      while (rw_ready_o !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) chk1("accept_timeout", 1'b0, 1'b1);
      acc = cyc;
      step();
   endtask

   task automatic await_data(output int dvc);
      int n;
      n = 0;
      while (data_valid_o !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) chk1("data_timeout", 1'b0, 1'b1);
      dvc = cyc;
   endtask

   task automatic release_data(input int hold);
      repeat (hold) step();
      data_ready_i = 1'b1;
      step();
      data_ready_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2, dvc, sel;
      logic [63:0] d0;
      logic [7:0]  sz;

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      chk1("rst_rw_ready",   rw_ready_o, 1'b1);
      chk1("rst_ar_valid",   axi_ar_valid_o, 1'b0);
      chk1("rst_r_ready",    axi_r_ready_o, 1'b0);
      chk1("rst_data_valid", data_valid_o, 1'b0);
      chk1("rst_err",        err_o, 1'b0);
      chk("rst_data",        data_read_o, 64'd0);
      chk("rst_ar_addr",     axi_ar_addr_o, 64'd0);

      // zero-wait word load
      set_slave(0, 0, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
      issue(64'h8000_0004, 8'd4, acc);
      rw_valid_i = 1'b0;
      chk1("t1_ar_valid", axi_ar_valid_o, 1'b1);
      chk("t1_ar_addr", axi_ar_addr_o, 64'h8000_0004);
      chk("t1_ar_size", 64'(axi_ar_size_o), 64'd2);
      chk("t1_ar_len",  64'(axi_ar_len_o), 64'd0);
      await_data(dvc);
      chk("t1_latency", 64'(dvc - acc), 64'd3);
      chk("t1_data", data_read_o, 64'h0000_0000_1122_3344);
      chk1("t1_err", err_o, 1'b0);
      release_data(0);

      // byte load with delayed arready/rvalid
      set_slave(5, 3, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
      issue(64'h8000_0003, 8'd1, acc);
      rw_valid_i = 1'b0;
      await_data(dvc);
      chk("t2_latency", 64'(dvc - acc), 64'd11);
      chk("t2_data", data_read_o, 64'h55);
      chk1("t2_err", err_o, 1'b0);
      release_data(0);

      // SLVERR on doubleword, then illegal size 3
      set_slave(0, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 1'b1);
      issue(64'h8000_0000, 8'd8, acc);
      rw_valid_i = 1'b0;
      await_data(dvc);
      chk("t3_data", data_read_o, 64'hDEAD_BEEF_CAFE_F00D);
      chk1("t3_err", err_o, 1'b1);
      release_data(0);
      set_slave(0, 0, 64'h0102_0304_0506_0708, 2'b00, 1'b1);
      issue(64'h8000_0010, 8'd3, acc);
      rw_valid_i = 1'b0;
      chk("t4_ar_size", 64'(axi_ar_size_o), 64'd3);
      await_data(dvc);
      chk1("t4_err", err_o, 1'b1);
      release_data(0);

      // consumer stalls 10 cycles with the next request already waiting
      set_slave(1, 1, 64'h1122_3344_5566_7788, 2'b00, 1'b1);
      issue(64'h8000_0106, 8'd2, acc);
      await_data(dvc);
      d0 = data_read_o;
      chk("t5_data", d0, 64'h1122);
      repeat (10) step();
      chk("t5_data_held", data_read_o, d0);
      chk1("t5_no_accept", rw_ready_o, 1'b0);
      chk1("t5_no_ar", axi_ar_valid_o, 1'b0);
      data_ready_i = 1'b1;
      step();
      data_ready_i = 1'b0;
      chk1("t5_next_accept", rw_ready_o, 1'b1);
      acc2 = cyc;
      step();
      rw_valid_i = 1'b0;
      chk1("t5_second_ar", axi_ar_valid_o, 1'b1);
      await_data(dvc);
      chk("t5_second_latency", 64'(dvc - acc2), 64'd5);
      release_data(0);

      // reset while waiting for R
      set_slave(0, 3, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b1);
      issue(64'h8000_0020, 8'd4, acc);
      rw_valid_i = 1'b0;
      step();
      chk1("t6_in_r", axi_r_ready_o, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1("t6_rw_ready", rw_ready_o, 1'b1);
      chk1("t6_r_ready", axi_r_ready_o, 1'b0);
      chk1("t6_data_valid", data_valid_o, 1'b0);
      chk("t6_data_clear", data_read_o, 64'd0);
      step();
      chk1("t6_r_ready_idle", axi_r_ready_o, 1'b0);
      set_slave(0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1);
      issue(64'h8000_0008, 8'd8, acc);
      rw_valid_i = 1'b0;
      await_data(dvc);
      chk("t6_post_latency", 64'(dvc - acc), 64'd3);
      chk("t6_post_data", data_read_o, 64'h0123_4567_89AB_CDEF);
      release_data(0);

      // randomized traffic, checked by the per-cycle model
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 8) sz = 8'(1 << (sel % 4));
         else sz = (sel == 8) ? 8'd3 : 8'($urandom_range(9, 255));
         set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                   ($urandom_range(0, 7) != 0));
         issue({$urandom, $urandom}, sz, acc);
         rw_valid_i = 1'b0;
         await_data(dvc);
         release_data(int'($urandom_range(0, 3)));
      end

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22041207_axi_rd_master.md
# ysyx_22041207_axi_rd_master

Single-outstanding AXI4 read master sitting directly downstream of the IF/MEM read arbiter. It accepts one granted read request on the simple request/response interface, issues a single-beat AXI AR transaction and collects the R beat. It then returns the byte-aligned, zero-extended load data to the arbiter with a valid/ready handshake. No write channels; no bursts; one transaction in flight at a time.

## Interface
- RW_DATA_WIDTH, 64, width of returned load data
- RW_ADDR_WIDTH, 64, request address width
- AXI_DATA_WIDTH, 64, R data width; only 64 is supported
- AXI_ADDR_WIDTH, 64, AR address width
- AXI_ID_WIDTH, 4, ARID/RID width
- AXI_USER_WIDTH, 1, ARUSER width, driven 0
- AR_ID, 0, constant ARID value
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  reset, synchronous to clk, active-high
- rw_valid_i  in  1  request valid from arbiter
- rw_ready_o  out  1  request accepted this cycle
- rw_addr_i  in  RW_ADDR_WIDTH  byte address
- rw_size_i  in  8  access bytes: 1, 2, 4 or 8
- data_read_o  out  RW_DATA_WIDTH  aligned load data
- data_valid_o  out  1  data_read_o/err_o valid
- data_ready_i  in  1  arbiter consumed data
- err_o  out  1  response error, qualified by data_valid_o
- axi_ar_valid_o, axi_ar_ready_i, axi_ar_addr_o[AXI_ADDR_WIDTH], axi_ar_id_o[AXI_ID_WIDTH], axi_ar_len_o[8], axi_ar_size_o[3], axi_ar_burst_o[2], axi_ar_user_o[AXI_USER_WIDTH]  AXI4 AR channel
- axi_r_valid_i, axi_r_ready_o, axi_r_data_i[AXI_DATA_WIDTH], axi_r_resp_i[2], axi_r_last_i, axi_r_id_i[AXI_ID_WIDTH]  AXI4 R channel

## Operation
- States: IDLE, AR, R, RESP.
- IDLE: rw_ready_o = 1 (combinational from state). rw_valid_i high -> latch addr and size -> AR.
- AR: axi_ar_valid_o = 1; address, size and ID are held stable until axi_ar_ready_i, then -> R.
- R: axi_r_ready_o = 1; on axi_r_valid_i, capture data; err = (resp != OKAY) | !axi_r_last_i | size_err; -> RESP. RID is not checked.
- RESP: data_valid_o = 1, data_read_o and err_o held; on data_ready_i -> IDLE.
- AR fields: araddr = latched address, unmodified; arlen = 0; arburst = INCR (2'b01); aruser = 0.
- Size map: 1→0, 2→1, 4→2, 8→3. Any other value → arsize 3 and size_err = 1; the transaction still runs.
- Data: shifted = rdata >> (addr[2:0]*8), masked to the low size bytes, zero-extended. No sign extension; the consumer sign-extends.
- Reset in any state: state to IDLE, and all state-dependent outputs (rw_ready_o follows state to 1) and captured data clear. A pending AXI response after reset is not tracked; a response arriving in IDLE is neither accepted nor acted on, because rready = 0.

## Timing
- Reset values: rw_ready_o = 1 (IDLE); axi_ar_valid_o, axi_r_ready_o, data_valid_o and err_o = 0; data_read_o = 0; axi_ar_addr_o = 0.
- Request accepted in cycle N. axi_ar_valid_o is high from N+1.
- If arready is high at N+1, rready is high from N+2. rvalid at N+2 gives data_valid_o at N+3.
- Minimum request-to-data latency is 3 cycles. Minimum back-to-back spacing is 4 cycles: the next accept can occur in the cycle after data_ready_i.
- rw_ready_o is 0 in AR, R and RESP; rw_valid_i is ignored there.
- data_valid_o is held until data_ready_i. A same-cycle ready completes the handshake in that cycle.
- AR valid is never dropped before arready (AXI rule). The bench asserts this, plus stability of ARADDR while valid.

## Structure
- Package ysyx_22041207_axi_pkg holds:
  - the state enum
  - AXI constants: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR
  - the size-to-arsize function
- Sub-module ysyx_22041207_rd_align: combinational shift/mask/zero-extend from (rdata, addr[2:0], size).
- The FSM and registers live in the top module.

## Test plan
- Reset for 2 cycles, then release. rw_ready_o = 1; all valids 0; data_read_o = 0.
- Request addr 0x8000_0004, size 4; slave has zero wait states; rdata 0x1122_3344_5566_7788, OKAY, last = 1 → ARADDR 0x8000_0004, arsize 2, arlen 0. data_read_o = 0x0000_0000_1122_3344, err_o = 0, valid at N+3.
- Request addr 0x8000_0003, size 1; arready delayed 5 cycles, rvalid delayed 3 cycles → AR held stable throughout; data_read_o = 0x0000_0000_0000_0055.
- Request size 8; rresp SLVERR → err_o = 1, data_read_o = full rdata. Then request size 3 with OKAY → arsize 3, err_o = 1.
- data_ready_i held low 10 cycles in RESP → data_valid_o and data stay stable. rw_valid_i stays high but rw_ready_o = 0 and no new AR is issued. The next accept occurs the cycle after data_ready_i.
- Assert rst while in R with rvalid pending → next cycle is IDLE, rready = 0, data_valid_o = 0. A new request then completes normally.
